// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//
// Program counter sequencer for the OTTER core. It selects the next PC from
// four sources: sequential, branch/JAL, JALR or trap. A misaligned branch or
// JALR target is redirected to TRAP_VEC. The block also handles boot, halt
// and resume, and records the previous PC for EPC use.
//
// Parameters:
//   XLEN         PC / address width
//   RESET_VECTOR PC loaded on reset
//   PC_INC       sequential increment
//   ALIGN_BITS   number of PC LSBs that must be zero in a legal target
//
// Ports:
//   clk          system clock, rising edge
//   PC_RST_N     synchronous active-low reset
//   PC_WRITE     advance request
//   PC_SEL       next-PC source: 0 seq, 1 branch/JAL, 2 JALR, 3 trap
//   BR_TARGET    branch/JAL target
//   JALR_TARGET  raw JALR sum; bit 0 is cleared here
//   TRAP_VEC     trap handler address
//   HALT         request to enter HALTED
//   RESUME       leave HALTED
//   PC_COUNT     current PC
//   PC_PLUS_INC  PC_COUNT + PC_INC (combinational, wraps)
//   PC_PREV      PC before the most recent accepted update
//   FETCH_VALID  PC_COUNT valid for fetch (RUN state)
//   MISALIGN     one-cycle pulse after a misaligned target was redirected
//   HALTED       high in HALTED state
//   state_dbg    current FSM state (0 BOOT, 1 RUN, 2 HALTED)
//   RETIRE_CNT   accepted-update counter (only when PC_RETIRE_CNT_EN is defined)
//
// Optional feature macro: PC_RETIRE_CNT_EN
//
// Handshake: PC_WRITE is a request with no ready return. It is accepted on a
// rising edge only when the state is RUN and HALT is low. A request made in
// any other condition is dropped, and the requester must assert it again.
// ---------------------------------------------------------------------------
module pc_sequencer #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              PC_INC       = 4,
    parameter int              ALIGN_BITS   = 2
) (
    input  logic            clk,
    input  logic            PC_RST_N,
    input  logic            PC_WRITE,
    input  logic [1:0]      PC_SEL,
    input  logic [XLEN-1:0] BR_TARGET,
    input  logic [XLEN-1:0] JALR_TARGET,
    input  logic [XLEN-1:0] TRAP_VEC,
    input  logic            HALT,
    input  logic            RESUME,
    output logic [XLEN-1:0] PC_COUNT,
    output logic [XLEN-1:0] PC_PLUS_INC,
    output logic [XLEN-1:0] PC_PREV,
    output logic            FETCH_VALID,
    output logic            MISALIGN,
    output logic            HALTED,
`ifdef PC_RETIRE_CNT_EN
    output logic [63:0]     RETIRE_CNT,
`endif
    output logic [1:0]      state_dbg
);

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] INC        = XLEN'(PC_INC);
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);
    localparam logic [XLEN-1:0] BIT0_CLR   = ~(XLEN'(1));

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, prev_q;
    logic              misalign_q;
    logic              accept;
    logic [XLEN-1:0]   candidate;
    logic              bad_align;
    logic [XLEN-1:0]   next_pc;

    // Next-PC source selection and alignment check.
    always_comb begin
        candidate = pc_q + INC;
        bad_align = 1'b0;
        case (PC_SEL)
            2'd0: candidate = pc_q + INC;
            2'd1: candidate = BR_TARGET;
            2'd2: candidate = JALR_TARGET & BIT0_CLR;
            2'd3: candidate = TRAP_VEC;
            default: candidate = pc_q + INC;
        endcase
        // Only branch/JAL and JALR targets are checked; the trap vector is
        // trusted as given.
        if (PC_SEL == 2'd1 || PC_SEL == 2'd2)
            bad_align = |(candidate & ALIGN_MASK);
        next_pc = bad_align ? TRAP_VEC : candidate;
    end

    // FSM next state and update acceptance.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                // HALT has priority over a simultaneous advance request.
                if (HALT) state_d = ST_HALTED;
                else      accept  = PC_WRITE;
            end
            ST_HALTED: begin
                // RESUME has priority over HALT held high.
                if (RESUME) state_d = ST_RUN;
            end
            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!PC_RST_N) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_VECTOR;
            prev_q     <= RESET_VECTOR;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            misalign_q <= accept & bad_align;
            if (accept) begin
                prev_q <= pc_q;
                pc_q   <= next_pc;
            end
        end
    end

`ifdef PC_RETIRE_CNT_EN
    logic [63:0] retire_q;

    always_ff @(posedge clk) begin
        if (!PC_RST_N)   retire_q <= '0;
        else if (accept) retire_q <= retire_q + 64'd1;
    end

    assign RETIRE_CNT = retire_q;
`endif

    assign PC_COUNT    = pc_q;
    assign PC_PLUS_INC = pc_q + INC;
    assign PC_PREV     = prev_q;
    assign FETCH_VALID = (state_q == ST_RUN);
    assign HALTED      = (state_q == ST_HALTED);
    assign MISALIGN    = misalign_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
//
// Directed testbench for pc_sequencer with RESET_VECTOR = 0x100. It walks
// through the following scenarios: reset and boot, sequential advance,
// aligned and misaligned JALR/branch, unchecked trap load, wrap past
// 0xFFFF_FFFC, halt/resume priority, and reset mid-run. When
// PC_RETIRE_CNT_EN is defined it also checks the retire counter.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

    localparam int XLEN = 32;

    logic            clk;
    logic            PC_RST_N;
    logic            PC_WRITE;
    logic [1:0]      PC_SEL;
    logic [XLEN-1:0] BR_TARGET;
    logic [XLEN-1:0] JALR_TARGET;
    logic [XLEN-1:0] TRAP_VEC;
    logic            HALT;
    logic            RESUME;
    logic [XLEN-1:0] PC_COUNT;
    logic [XLEN-1:0] PC_PLUS_INC;
    logic [XLEN-1:0] PC_PREV;
    logic            FETCH_VALID;
    logic            MISALIGN;
    logic            HALTED;
    logic [1:0]      state_dbg;
`ifdef PC_RETIRE_CNT_EN
    logic [63:0]     RETIRE_CNT;
`endif

    int checks   = 0;
    int failures = 0;

    pc_sequencer #(
        .XLEN        (XLEN),
        .RESET_VECTOR(32'h0000_0100),
        .PC_INC      (4),
        .ALIGN_BITS  (2)
    ) dut (
        .clk        (clk),
        .PC_RST_N   (PC_RST_N),
        .PC_WRITE   (PC_WRITE),
        .PC_SEL     (PC_SEL),
        .BR_TARGET  (BR_TARGET),
        .JALR_TARGET(JALR_TARGET),
        .TRAP_VEC   (TRAP_VEC),
        .HALT       (HALT),
        .RESUME     (RESUME),
        .PC_COUNT   (PC_COUNT),
        .PC_PLUS_INC(PC_PLUS_INC),
        .PC_PREV    (PC_PREV),
        .FETCH_VALID(FETCH_VALID),
        .MISALIGN   (MISALIGN),
        .HALTED     (HALTED),
`ifdef PC_RETIRE_CNT_EN
        .RETIRE_CNT (RETIRE_CNT),
`endif
        .state_dbg  (state_dbg)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_pc(input string tag, input logic [31:0] pc, input logic [31:0] prev);
        chk({tag, "_pc"}, 64'(PC_COUNT), 64'(pc));
        chk({tag, "_prev"}, 64'(PC_PREV), 64'(prev));
    endtask

    initial begin
        PC_RST_N    = 1'b0;
        PC_WRITE    = 1'b0;
        PC_SEL      = 2'd0;
        BR_TARGET   = '0;
        JALR_TARGET = '0;
        TRAP_VEC    = 32'h0000_0080;
        HALT        = 1'b0;
        RESUME      = 1'b0;

        // Reset held for two edges.
        step();
        step();
        chk_pc("rst", 32'h100, 32'h100);
        chk("rst_fv", 64'(FETCH_VALID), 64'd0);
        chk("rst_mis", 64'(MISALIGN), 64'd0);
        chk("rst_halted", 64'(HALTED), 64'd0);
        chk("rst_state", 64'(state_dbg), 64'd0);
`ifdef PC_RETIRE_CNT_EN
        chk("rst_retire", RETIRE_CNT, 64'd0);
`endif

        // BOOT cycle: HALT and PC_WRITE must both be ignored.
        PC_RST_N = 1'b1;
        HALT     = 1'b1;
        PC_WRITE = 1'b1;
        chk("boot_fv", 64'(FETCH_VALID), 64'd0);
        step();
        chk("boot_state", 64'(state_dbg), 64'd1);
        chk("run_fv", 64'(FETCH_VALID), 64'd1);
        chk_pc("boot", 32'h100, 32'h100);
        chk("run_inc", 64'(PC_PLUS_INC), 64'h104);
        HALT = 1'b0;

        // Three sequential advances.
        PC_SEL = 2'd0;
        step(); chk("seq1_pc", 64'(PC_COUNT), 64'h104);
        step(); chk("seq2_pc", 64'(PC_COUNT), 64'h108);
        step(); chk_pc("seq3", 32'h10C, 32'h108);

        // JALR with odd sum: bit 0 is cleared and the target is aligned.
        PC_SEL = 2'd2; JALR_TARGET = 32'h201;
        step();
        chk_pc("jalr", 32'h200, 32'h10C);
        chk("jalr_mis", 64'(MISALIGN), 64'd0);

        // Misaligned branch is redirected to the trap vector.
        PC_SEL = 2'd1; BR_TARGET = 32'h206;
        step();
        chk_pc("brmis", 32'h80, 32'h200);
        chk("brmis_mis", 64'(MISALIGN), 64'd1);
        PC_WRITE = 1'b0;
        step();
        chk("brmis_pulse_end", 64'(MISALIGN), 64'd0);
        chk_pc("idle", 32'h80, 32'h200);

        // Misaligned JALR: 0x203 becomes 0x202 after the bit-0 clear, which
        // is still misaligned.
        PC_WRITE = 1'b1; PC_SEL = 2'd2; JALR_TARGET = 32'h203;
        step();
        chk_pc("jalrmis", 32'h80, 32'h80);
        chk("jalrmis_mis", 64'(MISALIGN), 64'd1);

        // Trap source loads without an alignment check.
        PC_SEL = 2'd3; TRAP_VEC = 32'h82;
        step();
        chk_pc("trap", 32'h82, 32'h80);
        chk("trap_mis", 64'(MISALIGN), 64'd0);
        TRAP_VEC = 32'h80;

        // Wrap past the top of the address space.
        PC_SEL = 2'd1; BR_TARGET = 32'hFFFF_FFFC;
        step();
        chk("top_pc", 64'(PC_COUNT), 64'hFFFF_FFFC);
        chk("top_inc", 64'(PC_PLUS_INC), 64'h0);
        PC_SEL = 2'd0;
        step();
        chk_pc("wrap", 32'h0, 32'hFFFF_FFFC);

        // Halt wins over a simultaneous advance.
        PC_SEL = 2'd1; BR_TARGET = 32'h40;
        step();
        chk("to40_pc", 64'(PC_COUNT), 64'h40);
        PC_SEL = 2'd0; HALT = 1'b1;
        step();
        chk_pc("halt", 32'h40, 32'h0);
        chk("halt_halted", 64'(HALTED), 64'd1);
        chk("halt_fv", 64'(FETCH_VALID), 64'd0);
        chk("halt_state", 64'(state_dbg), 64'd2);
        HALT = 1'b0;
        step();
        step();
        chk("halted_pc_held", 64'(PC_COUNT), 64'h40);
        chk("halted_stays", 64'(HALTED), 64'd1);
        // RESUME together with HALT: RESUME wins.
        HALT = 1'b1; RESUME = 1'b1; PC_WRITE = 1'b0;
        step();
        chk("resume_halted", 64'(HALTED), 64'd0);
        chk("resume_fv", 64'(FETCH_VALID), 64'd1);
        chk("resume_pc", 64'(PC_COUNT), 64'h40);
        HALT = 1'b0; RESUME = 1'b0; PC_WRITE = 1'b1;
        step();
        chk_pc("post_resume", 32'h44, 32'h40);

        // Reset mid-run with PC_WRITE high.
        PC_SEL = 2'd1; BR_TARGET = 32'h300;
        step();
        chk("to300_pc", 64'(PC_COUNT), 64'h300);
`ifdef PC_RETIRE_CNT_EN
        chk("retire_total", RETIRE_CNT, 64'd12);
`endif
        PC_SEL = 2'd0; PC_RST_N = 1'b0;
        step();
        chk_pc("midrst", 32'h100, 32'h100);
        chk("midrst_state", 64'(state_dbg), 64'd0);
        chk("midrst_fv", 64'(FETCH_VALID), 64'd0);
`ifdef PC_RETIRE_CNT_EN
        chk("midrst_retire", RETIRE_CNT, 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised next-generation program counter for the OTTER core.
- Selects next PC from sequential, branch/JAL, JALR or trap sources.
- Checks target alignment and raises a trap redirect on misalignment.
- Supports stall, halt and resume, and records the previous PC for trap/EPC use. Sits between the control FSM/branch logic and instruction memory.

Parameters:
- XLEN, 32, PC and address width in bits.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset (XLEN bits).
- PC_INC, 4, sequential increment added to PC_COUNT.
- ALIGN_BITS, 2, number of PC LSBs that must be zero for a legal target.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- PC_RST_N  in  1  reset, synchronous, active-low
- PC_WRITE  in  1  advance request; PC updates this cycle when accepted
- PC_SEL  in  2  next-PC source: 0 seq, 1 branch/JAL, 2 JALR, 3 trap
- BR_TARGET  in  XLEN  branch/JAL target address
- JALR_TARGET  in  XLEN  raw JALR sum; bit 0 cleared internally
- TRAP_VEC  in  XLEN  trap handler address
- HALT  in  1  request to enter HALTED
- RESUME  in  1  leave HALTED
- PC_COUNT  out  XLEN  current PC
- PC_PLUS_INC  out  XLEN  PC_COUNT + PC_INC, combinational, wraps modulo 2^XLEN
- PC_PREV  out  XLEN  PC value before the most recent accepted update
- FETCH_VALID  out  1  PC_COUNT is valid for fetch
- MISALIGN  out  1  one-cycle pulse; misaligned target was redirected
- HALTED  out  1  high while in HALTED state

Behaviour:
- Reset: applies when PC_RST_N=0 at a clk edge, with priority over all inputs, including mid-operation.
  - PC_COUNT=RESET_VECTOR, PC_PREV=RESET_VECTOR.
  - FETCH_VALID=0, MISALIGN=0, HALTED=0, state=BOOT.
- States:
  - BOOT: one cycle with FETCH_VALID=0 and PC held. Then RUN unconditionally (HALT ignored in BOOT).
  - RUN: FETCH_VALID=1. If HALT=1, go to HALTED; otherwise process PC_WRITE.
  - HALTED: HALTED=1, FETCH_VALID=0. PC_WRITE is ignored and PC is held. If RESUME=1, go to RUN next cycle; PC is unchanged and no update is lost.
- HALT=1 together with PC_WRITE=1 in RUN: HALT wins. The PC is not updated, and the advance must be re-requested after resume.
- Accepted update (RUN, HALT=0, PC_WRITE=1): PC_PREV<=PC_COUNT, and PC_COUNT takes the next-PC value:
  - SEL=0: PC_COUNT+PC_INC, wrapping to 0 past 2^XLEN-1.
  - SEL=1: BR_TARGET.
  - SEL=2: JALR_TARGET with bit 0 forced to 0.
  - SEL=3: TRAP_VEC, loaded without an alignment check.
- Alignment check (SEL=1 or 2): if the candidate's low ALIGN_BITS bits are nonzero (after the bit-0 clear for JALR):
  - PC_COUNT<=TRAP_VEC, PC_PREV<=PC_COUNT.
  - MISALIGN=1 for exactly the following cycle.
- No update when PC_WRITE=0: PC_COUNT, PC_PREV held; MISALIGN=0.
- Latency: new PC is visible on PC_COUNT one cycle after the accepting edge. PC_PLUS_INC follows PC_COUNT combinationally.
- HALT and RESUME both high in HALTED: RESUME wins.

Optional Feature:
- Macro: PC_RETIRE_CNT_EN.
- Defined:
  - Adds output RETIRE_CNT [63:0], reset to 0 by PC_RST_N=0.
  - Increments by 1 on every accepted update, including misalign redirects.
  - Holds in BOOT/HALTED; wraps to 0 after 2^64-1.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset then release, RESET_VECTOR=32'h0000_0100 -> BOOT cycle FETCH_VALID=0, then PC_COUNT=0x100, FETCH_VALID=1, PC_PLUS_INC=0x104.
- PC=0x100, three cycles PC_WRITE=1, SEL=0 -> PC 0x104, 0x108, 0x10C; PC_PREV=0x108 at end.
- PC=0x10C, SEL=2, JALR_TARGET=0x201 -> PC=0x200, MISALIGN=0. Then SEL=1, BR_TARGET=0x206 -> PC=TRAP_VEC (0x80), MISALIGN pulse 1 cycle, PC_PREV=0x200.
- PC=0xFFFF_FFFC, SEL=0 -> PC=0x0000_0000 (wrap).
- RUN at PC=0x40, HALT=1 with PC_WRITE=1 -> PC stays 0x40, HALTED=1, FETCH_VALID=0. PC_WRITE pulses ignored. RESUME=1 -> RUN, PC still 0x40.
- Mid-run PC_RST_N=0 at PC=0x300 with PC_WRITE=1 -> next PC=RESET_VECTOR, state BOOT. With PC_RETIRE_CNT_EN: RETIRE_CNT=0 after reset, equals accepted-update count after the other scenarios.
